// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches with bounded outstanding requests,
// buffers {PC, instr} in a FIFO for decode, and flushes/discards stale responses on redirect.
module instr_prefetch_queue #(
  parameter int unsigned    DPW       = 32,
  parameter int unsigned    DEPTH     = 4,
  parameter int unsigned    MAX_OUTST = 2,
  parameter logic [DPW-1:0] RESET_PC  = '0
) (
  input  logic           clk,
  input  logic           rst,
  output logic           imem_req_valid,
  input  logic           imem_req_ready,
  output logic [DPW-1:0] imem_req_addr,
  input  logic           imem_rsp_valid,
  input  logic [DPW-1:0] imem_rsp_data,
  input  logic           redirect_valid,
  input  logic [DPW-1:0] redirect_pc,
  input  logic           stallD,
  output logic           instr_valid,
  output logic [DPW-1:0] instrD,
  output logic [DPW-1:0] PCD,
  output logic           spurious_rsp
);
  localparam int unsigned    AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned    CW  = $clog2(DEPTH + 1);
  localparam logic [DPW-1:0] NOP = DPW'(32'h0000_0013);

  typedef enum logic {FETCH, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [DPW-1:0] pc_q, pc_d;
  logic [CW-1:0]  outst_q, outst_d;
  logic [CW-1:0]  drop_q, drop_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic           spur_q, spur_d;

  logic [DPW-1:0] mem_pc_q   [DEPTH];
  logic [DPW-1:0] mem_data_q [DEPTH];

  logic [DPW-1:0] rsp_pc;
  logic [CW-1:0]  outst_rsp;
  logic           rsp_drop, rsp_spur, rsp_take;
  logic           credit_ok, req_fire, push, pop;

  always_comb begin
    // Responses return in order and no request issues while stale ones are pending,
    // so the oldest outstanding PC is pc_q minus one word per outstanding request.
    rsp_pc    = pc_q - (DPW'(outst_q) << 2);
    rsp_drop  = imem_rsp_valid && (drop_q != '0);
    rsp_spur  = imem_rsp_valid && (drop_q == '0) && (outst_q == '0);
    rsp_take  = imem_rsp_valid && (drop_q == '0) && (outst_q != '0);
    outst_rsp = outst_q - CW'(rsp_drop || rsp_take);

    credit_ok      = ({1'b0, cnt_q} + {1'b0, outst_q}) < (CW+1)'(DEPTH);
    imem_req_valid = (state_q == FETCH) && !redirect_valid &&
                     (outst_q < CW'(MAX_OUTST)) && credit_ok;
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;

    instr_valid  = (cnt_q != '0);
    instrD       = instr_valid ? mem_data_q[rd_q] : NOP;
    PCD          = instr_valid ? mem_pc_q[rd_q] : '0;
    spurious_rsp = spur_q;

    push = rsp_take && !redirect_valid;
    pop  = instr_valid && !stallD && !redirect_valid;

    state_d = state_q;
    pc_d    = pc_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    spur_d  = spur_q | rsp_spur;

    if (redirect_valid) begin
      // Everything still in flight after this cycle's response becomes stale.
      pc_d    = redirect_pc & ~DPW'(3);
      drop_d  = outst_rsp;
      outst_d = outst_rsp;
      state_d = (outst_rsp != '0) ? DRAIN : FETCH;
      cnt_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else begin
      pc_d    = req_fire ? pc_q + DPW'(4) : pc_q;
      drop_d  = drop_q - CW'(rsp_drop);
      outst_d = outst_rsp + CW'(req_fire);
      state_d = (drop_d == '0) ? FETCH : DRAIN;
      cnt_d   = cnt_q + CW'(push) - CW'(pop);
      wr_d    = wr_q + AW'(push);
      rd_d    = rd_q + AW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      spur_q  <= spur_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_pc_q[wr_q]   <= rsp_pc;
      mem_data_q[wr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomized bench for instr_prefetch_queue: a memory model feeds a scoreboard of expected
// decode entries; a negedge monitor compares the DUT against the scoreboard every cycle.
module tb_instr_prefetch_queue;
  localparam int          DPW      = 32;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] XORK     = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        stallD         = 1'b0;
  logic        instr_valid;
  logic [31:0] instrD, PCD;
  logic        spurious_rsp;

  always #5 clk = ~clk;

  instr_prefetch_queue #(.DPW(DPW), .DEPTH(DEPTH), .MAX_OUTST(MAXO), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stallD(stallD), .instr_valid(instr_valid), .instrD(instrD), .PCD(PCD),
    .spurious_rsp(spurious_rsp)
  );

  typedef struct {logic [31:0] addr; int ep; int rdy;} ost_t;
  typedef struct {logic [31:0] pc; logic [31:0] d; int vis;} exp_t;

  ost_t ost[$];     // accepted requests not yet answered by the memory model
  exp_t exp_q[$];   // expected decode entries, visible from cycle .vis onward

  int          cyc = 0, epoch = 0, total = 0, bad = 0, spur_from = -1;
  logic [31:0] exp_pc = RESET_PC;
  bit          checking = 0, rsp_now = 0, rsp_stale = 0;

  int lat_min = 1, lat_max = 1, ready_pct = 100, stall_pct = 0, redir_pct = 0, rsp_pct = 100;
  bit do_rst = 0, do_redir = 0, do_spur = 0, stall_force = 0;
  logic [31:0] redir_tgt = '0;
  bit hs_prev = 0, redir_prev = 0, rst_prev = 0;
  logic [31:0] tgt_prev = '0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, expv);
    end
  endfunction

  task automatic step();
    ost_t e;
    @(posedge clk); #1;
    cyc++;
    if (hs_prev) begin
      e.addr = exp_pc; e.ep = epoch;
      e.rdy  = cyc - 1 + int'($urandom_range(lat_max, lat_min));
      ost.push_back(e);
      exp_pc = exp_pc + 32'd4;
    end
    if (redir_prev) begin
      exp_pc = tgt_prev & 32'hFFFF_FFFC;
      epoch++;
    end
    if (rst_prev) begin
      ost.delete(); exp_q.delete();
      exp_pc = RESET_PC; spur_from = -1; epoch++;
    end
    rst = do_rst; do_rst = 0;
    redirect_valid = 1'b0;
    redirect_pc    = $urandom();
    if (!rst && (do_redir || int'($urandom_range(99)) < redir_pct)) begin
      redirect_valid = 1'b1;
      if (do_redir) redirect_pc = redir_tgt;
    end
    do_redir       = 0;
    stallD         = stall_force || (int'($urandom_range(99)) < stall_pct);
    imem_req_ready = int'($urandom_range(99)) < ready_pct;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom();
    rsp_now = 0; rsp_stale = 0;
    if (!rst && ost.size() > 0 && ost[0].rdy <= cyc && int'($urandom_range(99)) < rsp_pct) begin
      e = ost.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = e.addr ^ XORK;
      rsp_now = 1; rsp_stale = (e.ep != epoch);
      if (!rsp_stale && !redirect_valid)
        exp_q.push_back('{pc: e.addr, d: e.addr ^ XORK, vis: cyc + 1});
    end else if (!rst && do_spur && ost.size() == 0) begin
      imem_rsp_valid = 1'b1;
      if (spur_from < 0) spur_from = cyc + 1;
      do_spur = 0;
    end
    @(negedge clk);
    hs_prev    = !rst && imem_req_valid && imem_req_ready;
    redir_prev = !rst && redirect_valid;
    tgt_prev   = redirect_pc;
    rst_prev   = rst;
  endtask

  always @(negedge clk) begin
    int fn, outs, stale;
    bit ev, er;
    if (checking && !rst) begin
      fn = 0;
      foreach (exp_q[i]) if (exp_q[i].vis <= cyc) fn++;
      ev = (fn > 0);
      chk("instr_valid", 32'(instr_valid), 32'(ev));
      if (ev) begin
        chk("PCD", PCD, exp_q[0].pc);
        chk("instrD", instrD, exp_q[0].d);
      end else begin
        chk("instrD_nop", instrD, NOP);
        chk("PCD_idle", PCD, 32'h0);
      end
      outs  = ost.size() + int'(rsp_now);
      stale = int'(rsp_now && rsp_stale);
      foreach (ost[i]) if (ost[i].ep != epoch) stale++;
      er = !redirect_valid && stale == 0 && outs < MAXO && (fn + outs) < DEPTH;
      chk("req_valid", 32'(imem_req_valid), 32'(er));
      if (er) chk("req_addr", imem_req_addr, exp_pc);
      chk("spurious", 32'(spurious_rsp), 32'(spur_from >= 0 && cyc >= spur_from));
      if (ev && !stallD && !redirect_valid) void'(exp_q.pop_front());
      if (redirect_valid) exp_q.delete();
    end
  end

  initial begin
    int n;
    do_rst = 1; step();
    do_rst = 1; step();
    checking = 1;

    // Always-ready 1-cycle memory, no stall: sustained one instruction per cycle.
    for (int k = 0; k < 5; k++) step();
    n = 0;
    for (int k = 0; k < 30; k++) begin step(); n += int'(instr_valid); end
    chk("throughput", 32'(n), 32'd30);

    // Decode stall fills the FIFO, then drains in order.
    stall_force = 1;
    for (int k = 0; k < 10; k++) step();
    chk("full_no_req", 32'(imem_req_valid), 32'd0);
    stall_force = 0;
    for (int k = 0; k < 10; k++) step();

    // Long latency with two in flight, then redirect to an unaligned target.
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && ost.size() < 2; k++) step();
    chk("wait_two_outst", 32'(ost.size()), 32'd2);
    do_redir = 1; redir_tgt = 32'h0000_0103; step();
    for (int k = 0; k < 15; k++) step();

    // Redirect while a response lands and decode pops.
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 8; k++) step();
    do_redir = 1; redir_tgt = 32'h0000_0200; step();
    for (int k = 0; k < 6; k++) step();

    // Spurious response with nothing outstanding, then reset mid-stream.
    ready_pct = 0;
    for (int k = 0; k < 20 && ost.size() > 0; k++) step();
    chk("wait_idle", 32'(ost.size()), 32'd0);
    do_spur = 1; step();
    for (int k = 0; k < 4; k++) step();
    ready_pct = 100;
    for (int k = 0; k < 5; k++) step();
    do_rst = 1; step();
    for (int k = 0; k < 8; k++) step();

    // Address wrap at the top of the address space.
    do_redir = 1; redir_tgt = 32'hFFFF_FFF8; step();
    for (int k = 0; k < 10; k++) step();

    // Random traffic.
    lat_min = 1; lat_max = 4; ready_pct = 70; stall_pct = 30; redir_pct = 4; rsp_pct = 80;
    for (int k = 0; k < 2000; k++) step();
    redir_pct = 0; stall_pct = 0; ready_pct = 100; rsp_pct = 100;
    for (int k = 0; k < 20; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end
endmodule
